// File: rtl/nios2_jtag_debug_cmd_sync.sv
// Sysclk-side receiver for the Nios II JTAG debug port: strobe synchronisers,
// command capture, one-cycle action decode and a held command handshake.
module nios2_jtag_debug_cmd_sync #(
    parameter int unsigned DATA_W      = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACT_BIT     = 37
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vs_uir,
    input  logic                       vs_udr,
    input  logic [IR_W-1:0]            ir_in,
    input  logic [DATA_W-1:0]          sr,
    output logic [DATA_W-1:0]          jdo,
    output logic                       cmd_valid,
    output logic [IR_W-1:0]            cmd_ir,
    input  logic                       cmd_ready,
    output logic [(1 << IR_W)-1:0]     take_action,
    output logic [(1 << IR_W)-1:0]     take_no_action,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam int unsigned NUM_CMD = 1 << IR_W;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic                   uir_last;
    logic                   udr_last;
    logic                   uir_ev;
    logic                   udr_ev;
    logic                   accept;
    logic                   drop;
    logic [IR_W-1:0]        ir_q;

    // Strobe synchronisers followed by one edge-detect flop each.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync <= '0;
            udr_sync <= '0;
            uir_last <= 1'b0;
            udr_last <= 1'b0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_last <= uir_sync[SYNC_STAGES-1];
            udr_last <= udr_sync[SYNC_STAGES-1];
        end
    end

    // Rising edges only; falling edges of the strobes carry no meaning.
    assign uir_ev = uir_sync[SYNC_STAGES-1] & ~uir_last;
    assign udr_ev = udr_sync[SYNC_STAGES-1] & ~udr_last;

    // Command handshake state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus accept/drop decision for an arriving update-DR.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (udr_ev) begin
                    accept  = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (udr_ev) begin
                    if (cmd_ready) begin
                        accept = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (cmd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Captured command, IR latch, decoded pulses and sticky overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo            <= '0;
            cmd_ir         <= '0;
            ir_q           <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            cmd_valid      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            cmd_valid      <= (state_d == PEND);
            if (accept) begin
                jdo    <= sr;
                // udr sees the IR latched before this edge, even if uir lands now
                cmd_ir <= ir_q;
                if (sr[ACT_BIT]) begin
                    take_action <= NUM_CMD'(1) << ir_q;
                end else begin
                    take_no_action <= NUM_CMD'(1) << ir_q;
                end
            end
            if (uir_ev) begin
                ir_q <= ir_in;
            end
            // A fresh drop outranks a clear in the same cycle
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nios2_jtag_debug_cmd_sync.sv
// Bench for nios2_jtag_debug_cmd_sync: directed table, random run against a
// reference model, reset-in-flight and a wider/slower second build.
module tb_nios2_jtag_debug_cmd_sync;

    localparam int unsigned S = 2;

    logic        clk;
    logic        reset_n;
    logic        vs_uir, vs_udr, cmd_ready, overrun_clr;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic [37:0] jdo;
    logic        cmd_valid, overrun;
    logic [1:0]  cmd_ir;
    logic [3:0]  take_action, take_no_action;

    logic        vs_uir6, vs_udr6, cmd_ready6, overrun_clr6;
    logic [2:0]  ir_in6;
    logic [37:0] sr6;
    logic [37:0] jdo6;
    logic        cmd_valid6, overrun6;
    logic [2:0]  cmd_ir6;
    logic [7:0]  take_action6, take_no_action6;

    int n_vec = 0;
    int n_err = 0;

    nios2_jtag_debug_cmd_sync dut (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .jdo(jdo), .cmd_valid(cmd_valid),
        .cmd_ir(cmd_ir), .cmd_ready(cmd_ready), .take_action(take_action),
        .take_no_action(take_no_action), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    nios2_jtag_debug_cmd_sync #(.DATA_W(38), .IR_W(3), .SYNC_STAGES(3), .ACT_BIT(37)) dut6 (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir6), .vs_udr(vs_udr6),
        .ir_in(ir_in6), .sr(sr6), .jdo(jdo6), .cmd_valid(cmd_valid6),
        .cmd_ir(cmd_ir6), .cmd_ready(cmd_ready6), .take_action(take_action6),
        .take_no_action(take_no_action6), .overrun(overrun6),
        .overrun_clr(overrun_clr6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Directed vectors: one row per clock, expectations sampled after that edge.
    typedef struct {
        logic        uir, udr;
        logic [1:0]  ir;
        logic [37:0] sr;
        logic        rdy, clr;
        logic [3:0]  ta, tna;
        logic        cv, ovr;
        logic [37:0] jdo;
        logic [1:0]  cir;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic uir, input logic udr, input logic [1:0] ir,
                                input logic [37:0] s, input logic rdy, input logic clr,
                                input logic [3:0] ta, input logic [3:0] tna, input logic cv,
                                input logic ovr, input logic [37:0] j, input logic [1:0] cir);
        vec_t v;
        v.uir = uir; v.udr = udr; v.ir = ir; v.sr = s; v.rdy = rdy; v.clr = clr;
        v.ta = ta; v.tna = tna; v.cv = cv; v.ovr = ovr; v.jdo = j; v.cir = cir;
        return v;
    endfunction

    // Reference model: events derived from sample history, command rules applied per edge.
    logic [7:0]  h_udr, h_uir;
    logic        m_pend, m_ovr;
    logic [37:0] m_jdo;
    logic [1:0]  m_cir, m_irq;
    logic [3:0]  m_ta, m_tna;

    task automatic model_reset();
        h_udr = '0; h_uir = '0; m_pend = 1'b0; m_ovr = 1'b0; m_jdo = '0;
        m_cir = '0; m_irq = '0; m_ta = '0; m_tna = '0;
    endtask

    task automatic model_step();
        logic u_ev, i_ev, drop_now;
        h_udr = {h_udr[6:0], vs_udr};
        h_uir = {h_uir[6:0], vs_uir};
        u_ev = h_udr[S] && !h_udr[S+1];
        i_ev = h_uir[S] && !h_uir[S+1];
        m_ta = '0;
        m_tna = '0;
        drop_now = u_ev && m_pend && !cmd_ready;
        if (u_ev && !drop_now) begin
            m_jdo = sr;
            m_cir = m_irq;
            if (sr[37]) m_ta = 4'(1) << m_irq;
            else        m_tna = 4'(1) << m_irq;
            m_pend = 1'b1;
        end else if (!u_ev && cmd_ready) begin
            m_pend = 1'b0;
        end
        if (drop_now) m_ovr = 1'b1;
        else if (overrun_clr) m_ovr = 1'b0;
        if (i_ev) m_irq = ir_in;
    endtask

    task automatic zero_inputs();
        vs_uir = 1'b0; vs_udr = 1'b0; ir_in = '0; sr = '0; cmd_ready = 1'b0; overrun_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        zero_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    localparam logic [37:0] S1 = 38'h20_1234_5678;
    localparam logic [37:0] S2 = 38'h00_1234_5678;
    localparam logic [37:0] S3 = 38'h3F_FFFF_0000;
    localparam logic [37:0] S4 = 38'h21_0000_00AA;
    localparam logic [37:0] S5 = 38'h00_0000_0001;

    initial begin
        reset_n = 1'b0;
        zero_inputs();
        vs_uir6 = 1'b0; vs_udr6 = 1'b0; ir_in6 = '0; sr6 = '0;
        cmd_ready6 = 1'b0; overrun_clr6 = 1'b0;
        model_reset();

        tbl[0]  = mk(1,0,2,'0,0,0, 0,0,0,0,'0,0);
        tbl[1]  = mk(0,0,2,'0,0,0, 0,0,0,0,'0,0);
        tbl[2]  = mk(0,1,2,S1,0,0, 0,0,0,0,'0,0);
        tbl[3]  = mk(0,1,2,S1,0,0, 0,0,0,0,'0,0);
        tbl[4]  = mk(0,0,2,S1,0,0, 4'b0100,0,1,0,S1,2);
        tbl[5]  = mk(0,0,2,S1,0,0, 0,0,1,0,S1,2);
        tbl[6]  = mk(0,0,2,S1,1,0, 0,0,0,0,S1,2);
        tbl[7]  = mk(0,1,2,S2,0,0, 0,0,0,0,S1,2);
        tbl[8]  = mk(0,0,2,S2,0,0, 0,0,0,0,S1,2);
        tbl[9]  = mk(0,0,2,S2,0,0, 0,4'b0100,1,0,S2,2);
        tbl[10] = mk(0,0,2,S2,0,0, 0,0,1,0,S2,2);
        tbl[11] = mk(0,1,2,S3,0,0, 0,0,1,0,S2,2);
        tbl[12] = mk(0,0,2,S3,0,0, 0,0,1,0,S2,2);
        tbl[13] = mk(0,0,2,S3,0,0, 0,0,1,1,S2,2);
        tbl[14] = mk(0,0,2,S3,0,1, 0,0,1,0,S2,2);
        tbl[15] = mk(0,0,2,S3,0,0, 0,0,1,0,S2,2);
        tbl[16] = mk(1,1,3,S4,0,0, 0,0,1,0,S2,2);
        tbl[17] = mk(0,0,3,S4,0,0, 0,0,1,0,S2,2);
        tbl[18] = mk(0,0,3,S4,1,0, 4'b0100,0,1,0,S4,2);
        tbl[19] = mk(0,0,3,S4,0,0, 0,0,1,0,S4,2);
        tbl[20] = mk(0,0,3,S4,1,0, 0,0,0,0,S4,2);
        tbl[21] = mk(0,1,3,S5,0,0, 0,0,0,0,S4,2);
        tbl[22] = mk(0,0,3,S5,0,0, 0,0,0,0,S4,2);
        tbl[23] = mk(0,0,3,S5,0,0, 0,4'b1000,1,0,S5,3);
        tbl[24] = mk(0,0,3,S5,1,0, 0,0,0,0,S5,3);
        tbl[25] = mk(0,0,3,S5,1,0, 0,0,0,0,S5,3);

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({take_action, take_no_action, cmd_valid, overrun, jdo, cmd_ir}), 64'd0);
        chk("reset_outputs6", 64'({take_action6, cmd_valid6, overrun6, cmd_ir6}), 64'd0);
        reset_n = 1'b1;

        // Directed table
        for (int i = 0; i < 26; i++) begin
            vs_uir = tbl[i].uir; vs_udr = tbl[i].udr; ir_in = tbl[i].ir; sr = tbl[i].sr;
            cmd_ready = tbl[i].rdy; overrun_clr = tbl[i].clr;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl[%0d] {ta,tna,cv,ovr,jdo,cir}", i),
                64'({take_action, take_no_action, cmd_valid, overrun, jdo, cmd_ir}),
                64'({tbl[i].ta, tbl[i].tna, tbl[i].cv, tbl[i].ovr, tbl[i].jdo, tbl[i].cir}));
        end

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(3) == 0) vs_udr = ~vs_udr;
            if ($urandom_range(4) == 0) vs_uir = ~vs_uir;
            ir_in = 2'($urandom);
            sr = {6'($urandom), 32'($urandom)};
            cmd_ready = ($urandom_range(2) == 0);
            overrun_clr = ($urandom_range(7) == 0);
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk($sformatf("rand[%0d] {ta,tna,cv,ovr,jdo,cir}", c),
                64'({take_action, take_no_action, cmd_valid, overrun, jdo, cmd_ir}),
                64'({m_ta, m_tna, m_pend, m_ovr, m_jdo, m_cir}));
        end

        // Reset while a command is pending with overrun set
        do_reset();
        vs_udr = 1'b1; sr = S1;
        @(negedge clk); vs_udr = 1'b0;
        repeat (4) @(negedge clk);
        vs_udr = 1'b1; sr = S2;
        @(negedge clk); vs_udr = 1'b0;
        repeat (4) @(negedge clk);
        chk("pend_overrun {cv,ovr,jdo}", 64'({cmd_valid, overrun, jdo}), 64'({1'b1, 1'b1, S1}));
        #2 reset_n = 1'b0;
        #1 chk("async_reset {cv,ovr,jdo}", 64'({cmd_valid, overrun, jdo}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("post_reset[%0d] {ta,tna,cv}", k),
                64'({take_action, take_no_action, cmd_valid}), 64'd0);
        end

        // Three-stage synchroniser, 3-bit IR build
        vs_uir6 = 1'b1; ir_in6 = 3'd5;
        @(negedge clk); vs_uir6 = 1'b0;
        repeat (6) @(negedge clk);
        vs_udr6 = 1'b1; sr6 = 38'h20_0000_0001;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vs_udr6 = 1'b0;
            chk($sformatf("sync3_edge%0d take_action6", k), 64'(take_action6),
                (k == 4) ? 64'h20 : 64'h0);
        end
        @(negedge clk);
        chk("sync3_after {ta,tna,cv,cir,jdo}",
            64'({take_action6, take_no_action6, cmd_valid6, cmd_ir6, jdo6}),
            64'({8'h00, 8'h00, 1'b1, 3'd5, 38'h20_0000_0001}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
